// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA colour scheduler: colour width, number of
// requesters, the scheduler state encoding, the power-on colour and two small
// helpers for turning a one-hot grant into a round-robin pointer.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int RGB_W   = 6;   // RRGGBB
  localparam int NUM_REQ = 3;
  localparam int PTR_W   = 2;   // enough to index NUM_REQ requesters

  localparam logic [RGB_W-1:0] DEFAULT_COLOR = 6'b001100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Index of the set bit in a one-hot requester vector (0 when none set).
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] onehot);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (onehot[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  // Round-robin successor: (idx + 1) mod NUM_REQ.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter_3.sv
// -----------------------------------------------------------------------------
// rr_arbiter_3
// Combinational three-way round-robin arbiter. The requester at 'pointer'
// has highest priority, then pointer+1, then pointer+2 (mod 3).
//   req     - request vector, one bit per requester
//   pointer - current highest-priority requester index
//   winner  - one-hot winner, all zeros when nothing is requested
// -----------------------------------------------------------------------------
module rr_arbiter_3
  import vga_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every variable assigned here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(pointer) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_color_scheduler.sv
// -----------------------------------------------------------------------------
// vga_color_scheduler
// Arbitrates colour-change requests from three requesters and applies the
// winning colour to the VGA output only on a frame_start pulse (vertical
// blanking), followed by a cooldown of HOLD_FRAMES frames before the next grant.
//   pixel_clk   - pixel clock, all state changes on its rising edge
//   reset_n     - asynchronous active-low reset
//   frame_start - one-cycle pulse at the first line of vertical blanking
//   req         - per-requester level request, held until granted
//   req_color   - requester i colour in bits [6i+5:6i], RRGGBB
//   grant       - one-hot, one-cycle grant pulse
//   color_data  - active RRGGBB colour
//   pending     - high while a granted colour waits for frame_start
//   commit      - one-cycle pulse in the cycle color_data takes a new value
// -----------------------------------------------------------------------------
module vga_color_scheduler #(
  parameter logic [vga_pkg::RGB_W-1:0] DEFAULT_COLOR = vga_pkg::DEFAULT_COLOR,
  parameter int                        HOLD_FRAMES   = 1   // 0..15
) (
  input  logic                                        pixel_clk,
  input  logic                                        reset_n,
  input  logic                                        frame_start,
  input  logic [vga_pkg::NUM_REQ-1:0]                 req,
  input  logic [vga_pkg::NUM_REQ*vga_pkg::RGB_W-1:0]  req_color,
  output logic [vga_pkg::NUM_REQ-1:0]                 grant,
  output logic [vga_pkg::RGB_W-1:0]                   color_data,
  output logic                                        pending,
  output logic                                        commit
);

  import vga_pkg::*;

  state_t             state;
  logic [PTR_W-1:0]   pointer;
  logic [3:0]         cooldown;
  logic [RGB_W-1:0]   shadow;

  logic [NUM_REQ-1:0] winner;
  logic [RGB_W-1:0]   win_color;

  rr_arbiter_3 u_arb (
    .req     (req),
    .pointer (pointer),
    .winner  (winner)
  );

  // Colour of the current arbitration winner; constant-index loop keeps the
  // selects static.
  always_comb begin
    win_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_color = req_color[i*RGB_W +: RGB_W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pointer    <= '0;
      cooldown   <= '0;
      // NOTE: the shadow is a single register, not a memory, so it is reset
      // too; a reset while PENDING must throw the granted colour away.
      shadow     <= DEFAULT_COLOR;
      color_data <= DEFAULT_COLOR;
      grant      <= '0;
      pending    <= 1'b0;
      commit     <= 1'b0;
    end else begin
      grant  <= '0;
      commit <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start && cooldown != 4'd0) cooldown <= cooldown - 4'd1;
          // A frame_start seen on the grant edge only counts down the
          // cooldown; the commit waits for the next frame_start.
          if (cooldown == 4'd0 && |req) begin
            grant   <= winner;
            shadow  <= win_color;
            pointer <= next_ptr(onehot_to_idx(winner));
            pending <= 1'b1;
            state   <= PENDING;
          end
        end
        PENDING: begin
          if (frame_start) begin
            color_data <= shadow;
            commit     <= 1'b1;
            pending    <= 1'b0;
            state      <= COMMIT;
          end
        end
        COMMIT: begin
          cooldown <= 4'(HOLD_FRAMES);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_color_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_color_scheduler
// Three scheduler instances (HOLD_FRAMES 0, default 1, 2) share one stimulus.
// A behavioural model per instance predicts every output each cycle, and
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_vga_color_scheduler;

  localparam logic [5:0] RST_COLOR = 6'b001100;

  logic        pixel_clk;
  logic        reset_n;
  logic        frame_start;
  logic [2:0]  req;
  logic [17:0] req_color;

  logic [2:0]  grant_o   [3];
  logic [5:0]  color_o   [3];
  logic        pending_o [3];
  logic        commit_o  [3];

  vga_color_scheduler #(.HOLD_FRAMES(0)) d0 (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .frame_start(frame_start),
    .req(req), .req_color(req_color), .grant(grant_o[0]),
    .color_data(color_o[0]), .pending(pending_o[0]), .commit(commit_o[0]));

  vga_color_scheduler d1 (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .frame_start(frame_start),
    .req(req), .req_color(req_color), .grant(grant_o[1]),
    .color_data(color_o[1]), .pending(pending_o[1]), .commit(commit_o[1]));

  vga_color_scheduler #(.HOLD_FRAMES(2)) d2 (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .frame_start(frame_start),
    .req(req), .req_color(req_color), .grant(grant_o[2]),
    .color_data(color_o[2]), .pending(pending_o[2]), .commit(commit_o[2]));

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // sel: 0 grant, 1 color_data, 2 pending, 3 commit
  task automatic check_one(input string name, input int i, input int sel, input logic [31:0] exp);
    logic [31:0] act;
    case (sel)
      0:       act = 32'(grant_o[i]);
      1:       act = 32'(color_o[i]);
      2:       act = 32'(pending_o[i]);
      default: act = 32'(commit_o[i]);
    endcase
    check($sformatf("%s/d%0d", name, i), act, exp);
  endtask

  task automatic check_all(input string name, input int sel, input logic [31:0] exp);
    for (int i = 0; i < 3; i++) check_one(name, i, sel, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a granted colour waits for a frame, then is shown;
  // the frame after showing starts a cooldown of 'hold' frames.
  // ---------------------------------------------------------------------------
  int         m_hold [3] = '{0, 1, 2};
  logic [2:0] e_grant   [3];
  logic [5:0] e_color   [3];
  logic       e_pending [3];
  logic       e_commit  [3];
  logic [5:0] m_shadow  [3];
  int         m_cool [3];
  int         m_ptr  [3];
  bit         m_waiting [3];
  bit         m_shown   [3];
  int         m_w, m_j, m_rv;

  always @(posedge pixel_clk or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        e_grant[i] = 3'b000;  e_color[i] = RST_COLOR;
        e_pending[i] = 1'b0;  e_commit[i] = 1'b0;
        m_shadow[i] = RST_COLOR;
        m_cool[i] = 0;  m_ptr[i] = 0;
        m_waiting[i] = 1'b0;  m_shown[i] = 1'b0;
      end else begin
        e_grant[i]  = 3'b000;
        e_commit[i] = 1'b0;
        if (m_waiting[i]) begin
          if (frame_start) begin
            e_color[i]   = m_shadow[i];
            e_commit[i]  = 1'b1;
            e_pending[i] = 1'b0;
            m_waiting[i] = 1'b0;
            m_shown[i]   = 1'b1;
          end
        end else if (m_shown[i]) begin
          m_shown[i] = 1'b0;
          m_cool[i]  = m_hold[i];
        end else begin
          m_w  = -1;
          m_rv = int'(req);
          if (m_cool[i] == 0) begin
            for (int k = 0; k < 3; k++) begin
              m_j = (m_ptr[i] + k) % 3;
              if (m_w < 0 && ((m_rv >> m_j) & 1) == 1) m_w = m_j;
            end
          end
          if (frame_start && m_cool[i] > 0) m_cool[i] = m_cool[i] - 1;
          if (m_w >= 0) begin
            e_grant[i]   = 3'(1 << m_w);
            m_shadow[i]  = 6'(req_color >> (6 * m_w));
            m_ptr[i]     = (m_w + 1) % 3;
            m_waiting[i] = 1'b1;
            e_pending[i] = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: every output of every instance on every falling edge.
  logic [2:0] g0_log[$];
  logic [5:0] c0_log[$];

  always @(negedge pixel_clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model.grant/d%0d", i),      32'(grant_o[i]),   32'(e_grant[i]));
      check($sformatf("model.color_data/d%0d", i), 32'(color_o[i]),   32'(e_color[i]));
      check($sformatf("model.pending/d%0d", i),    32'(pending_o[i]), 32'(e_pending[i]));
      check($sformatf("model.commit/d%0d", i),     32'(commit_o[i]),  32'(e_commit[i]));
    end
    if (grant_o[0] != 3'b000) g0_log.push_back(grant_o[0]);
    if (commit_o[0])          c0_log.push_back(color_o[0]);
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pixel_clk);
      #1;
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  // Drop all requests and run enough frames to drain any pending colour and
  // the longest cooldown.
  task automatic settle();
    req = 3'b000;
    repeat (4) begin
      tick(2);
      frame();
    end
    tick(2);
  endtask

  initial begin
    frame_start = 1'b0;
    req         = 3'b000;
    req_color   = '0;
    reset_n     = 1'b1;
    #2 reset_n  = 1'b0;
    #1;
    check_all("reset.color", 1, 32'(RST_COLOR));
    check_all("reset.grant", 0, 32'd0);
    check_all("reset.pending", 2, 32'd0);
    tick(2);
    reset_n = 1'b1;

    // Idle frames: colour stays at the reset value, nothing happens.
    repeat (3) begin
      tick(3);
      frame();
      check_all("idle.commit", 3, 32'd0);
      check_all("idle.color", 1, 32'(RST_COLOR));
    end

    // All three request; HOLD_FRAMES=0 instance rotates 001, 010, 100.
    g0_log.delete();
    c0_log.delete();
    req_color = {6'b111111, 6'b000011, 6'b110000};
    req = 3'b111;
    tick(1);
    check_all("rr.first_grant", 0, 32'b001);
    tick(2);
    frame();
    check_all("rr.first_commit", 3, 32'd1);
    check_all("rr.first_color", 1, 32'b110000);
    tick(3); frame();
    tick(3); frame();
    tick(3);
    check("rr.grant_count", 32'(g0_log.size() >= 3), 32'd1);
    check("rr.commit_count", 32'(c0_log.size() >= 3), 32'd1);
    if (g0_log.size() >= 3 && c0_log.size() >= 3) begin
      check("rr.grant0", 32'(g0_log[0]), 32'b001);
      check("rr.grant1", 32'(g0_log[1]), 32'b010);
      check("rr.grant2", 32'(g0_log[2]), 32'b100);
      check("rr.color0", 32'(c0_log[0]), 32'b110000);
      check("rr.color1", 32'(c0_log[1]), 32'b000011);
      check("rr.color2", 32'(c0_log[2]), 32'b111111);
    end
    settle();

    // Colour changed while PENDING is ignored.
    req_color[5:0] = 6'b110000;
    req = 3'b001;
    tick(1);
    check_all("shadow.pending", 2, 32'd1);
    req = 3'b000;
    req_color[5:0] = 6'b000011;
    tick(3);
    frame();
    check_all("shadow.commit", 3, 32'd1);
    check_all("shadow.color", 1, 32'b110000);
    settle();

    // frame_start on the grant edge does not commit.
    req_color = {6'b101010, 6'b010101, 6'b000011};
    req = 3'b010;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check_all("coincident.grant", 0, 32'b010);
    check_all("coincident.commit", 3, 32'd0);
    tick(3);
    check_all("coincident.still_pending", 2, 32'd1);
    check_all("coincident.no_commit", 3, 32'd0);
    req = 3'b000;
    frame();
    check_all("coincident.late_commit", 3, 32'd1);
    check_all("coincident.color", 1, 32'b010101);
    settle();

    // frame_start in the first PENDING cycle commits.
    req = 3'b100;
    tick(1);
    check_all("first_pending.grant", 0, 32'b100);
    frame_start = 1'b1;
    req = 3'b000;
    tick(1);
    frame_start = 1'b0;
    check_all("first_pending.commit", 3, 32'd1);
    check_all("first_pending.color", 1, 32'b101010);
    settle();

    // HOLD_FRAMES=2 cooldown on d2 with req held.
    req_color[5:0] = 6'b111000;
    req = 3'b001;
    tick(1);
    tick(1);
    frame();                                        // frame F
    check_one("hold2.commit_F", 2, 3, 32'd1);
    tick(1);
    tick(2);
    frame();                                        // frame F+1
    tick(3);
    check_one("hold2.blocked_F1", 2, 2, 32'd0);
    frame();                                        // frame F+2
    check_one("hold2.blocked_F2.pending", 2, 2, 32'd0);
    check_one("hold2.blocked_F2.grant", 2, 0, 32'd0);
    tick(1);
    check_one("hold2.grant_after_F2", 2, 0, 32'b001);
    check_one("hold2.pending_after_F2", 2, 2, 32'd1);
    tick(2);
    frame();                                        // frame F+3
    check_one("hold2.commit_F3", 2, 3, 32'd1);
    settle();

    // Request dropped during cooldown leaves no trace.
    req = 3'b001;
    tick(1);
    req = 3'b000;
    tick(1);
    frame();
    tick(1);
    req = 3'b100;
    tick(2);
    req = 3'b000;
    repeat (3) begin
      tick(2);
      frame();
    end
    tick(2);
    check_one("drop.pending", 1, 2, 32'd0);
    check_one("drop.pending", 2, 2, 32'd0);
    check_one("drop.color", 1, 1, 32'b111000);
    check_one("drop.color", 2, 1, 32'b111000);
    check_one("drop.d0_served", 0, 1, 32'b101010);
    settle();

    // Reset while PENDING discards the shadow colour.
    req_color[11:6] = 6'b011110;
    req = 3'b010;
    tick(1);
    req = 3'b000;
    tick(2);
    check_all("rst_pending.pending", 2, 32'd1);
    reset_n = 1'b0;
    #1;
    check_all("rst_pending.color", 1, 32'(RST_COLOR));
    check_all("rst_pending.cleared", 2, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    frame();
    check_all("rst_pending.no_commit", 3, 32'd0);
    check_all("rst_pending.color_kept", 1, 32'(RST_COLOR));
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_color_scheduler.md
VGA_COLOR_SCHEDULER -- requirements
Module: vga_color_scheduler

Interface
REQ-001 Parameter DEFAULT_COLOR, 6'b001100, RRGGBB colour driven after reset.
REQ-002 Parameter HOLD_FRAMES, 1, frames of cooldown after a commit before the next grant; legal range 0-15.
REQ-003 pixel_clk  input  1  25 MHz pixel clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 frame_start  input  1  one-cycle pulse from the timing generator at the first line of vertical blanking.
REQ-006 req  input  3  per-requester colour-change request; level, held until granted.
REQ-007 req_color  input  18  requested colours; requester i uses bits [6i+5:6i], RRGGBB.
REQ-008 grant  output  3  one-hot, one-cycle grant pulse.
REQ-009 color_data  output  6  active colour to VGA_Top color_data, RRGGBB.
REQ-010 pending  output  1  high while a granted colour awaits commit.
REQ-011 commit  output  1  one-cycle pulse in the cycle color_data takes the new value.

Function
REQ-012 The FSM SHALL have states IDLE, PENDING, COMMIT; all outputs registered.
REQ-013 IDLE: if any req bit is high and cooldown==0 at edge N, then in cycle N+1 grant SHALL be one-hot for the round-robin winner, shadow SHALL hold the winner's req_color sampled at edge N, state SHALL be PENDING.
REQ-014 Round-robin: pointer = 0 after reset; highest priority goes to pointer, then pointer+1, pointer+2 (mod 3); after granting i, pointer SHALL become (i+1) mod 3.
REQ-015 PENDING: pending=1; no grants; req and req_color changes SHALL be ignored; on frame_start, next cycle color_data<=shadow, commit=1, state COMMIT.
REQ-016 COMMIT: lasts exactly one cycle; cooldown<=HOLD_FRAMES; state SHALL return to IDLE.
REQ-017 Cooldown SHALL decrement by 1 on each frame_start while nonzero and in IDLE, saturating at 0; grants SHALL be blocked while nonzero.
REQ-018 frame_start coincident with a grant decision in IDLE SHALL NOT commit that grant; commit waits for the next frame_start.
REQ-019 frame_start in the cycle of entering PENDING (cycle N+1) SHALL trigger the commit.
REQ-020 HOLD_FRAMES=0: a new grant SHALL be possible in the cycle after COMMIT.
REQ-021 color_data SHALL change only in a commit cycle, hence only during vertical blanking.
REQ-022 A requester whose req drops before grant SHALL lose the request with no side effects.

Reset
REQ-023 reset_n low SHALL immediately force: state IDLE, color_data=DEFAULT_COLOR, grant=0, pending=0, commit=0, pointer=0, cooldown=0, shadow=DEFAULT_COLOR.
REQ-024 Reset in PENDING SHALL discard the shadow colour; no commit SHALL follow the release of reset.
REQ-025 After release, the first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-026 Shared package vga_pkg SHALL hold RGB_W=6, NUM_REQ=3, the FSM state encoding and DEFAULT_COLOR.
REQ-027 Round-robin logic SHALL be one sub-module, rr_arbiter_3 (inputs req, pointer; output one-hot winner; combinational).
REQ-028 Cooldown counter 4 bits; shadow register 6 bits; no other storage.

Verification
REQ-029 Reset, no req, 3 frame_start pulses -> color_data=6'b001100 throughout, grant=0, commit=0.
REQ-030 req=3'b111, colours 6'b110000/6'b000011/6'b111111 for req 0/1/2, HOLD_FRAMES=0, one frame_start per grant -> grants in order 001, 010, 100; color_data 110000, 000011, 111111 each after commit.
REQ-031 req=001 with req_color 6'b110000, then req_color changed to 6'b000011 while PENDING -> commit drives 6'b110000.
REQ-032 HOLD_FRAMES=2, req held after commit at frame F -> no grant until after frame_start F+2; commit at F+3.
REQ-033 grant and frame_start in same cycle -> no commit; commit on the following frame_start.
REQ-034 reset_n pulsed low while PENDING -> color_data=6'b001100, pending=0, no commit on the next frame_start.
